// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with saturating counters, plus ID-stage
// branch resolution that raises redirects and keeps performance counters.
module branch_predictor_bht #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] IF_pc,
  output logic              IF_pred_taken,
  output logic [ADDR_W-1:0] IF_pred_target,
  input  logic              ID_valid,
  input  logic [31:0]       ID_instruction,
  input  logic [ADDR_W-1:0] ID_pcplus4,
  input  logic [DATA_W-1:0] ID_read_data1,
  input  logic [DATA_W-1:0] ID_read_data2,
  input  logic              ID_pred_taken,
  input  logic [ADDR_W-1:0] ID_pred_target,
  output logic              pcsrc,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              IFID_flush,
  output logic [15:0]       branch_count,
  output logic [15:0]       mispredict_count
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BGE  = 6'b000101;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  // Fetch-side lookup always sees the pre-edge table contents
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;

  assign if_idx = IF_pc[IDX_W+1:2];
  assign if_tag = IF_pc[ADDR_W-1:IDX_W+2];

  assign IF_pred_taken  = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][CNT_W-1];
  assign IF_pred_target = IF_pred_taken ? target_q[if_idx] : IF_pc + ADDR_W'(4);

  // Decode and resolve the instruction in ID
  logic [5:0]        opcode;
  logic              is_jump, is_beq, is_bne, is_blt, is_bge, is_cti;
  logic              lt, taken;
  logic [ADDR_W-1:0] br_imm, br_target, j_target, act_target, id_pc;
  logic [IDX_W-1:0]  id_idx;
  logic [TAG_W-1:0]  id_tag;
  logic              id_hit;

  assign opcode  = ID_instruction[31:26];
  assign is_jump = (opcode == OP_JUMP);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_blt  = (opcode == OP_BLT);
  assign is_bge  = (opcode == OP_BGE);
  assign is_cti  = is_jump | is_beq | is_bne | is_blt | is_bge;

  assign lt = (SIGNED_CMP != 0) ? ($signed(ID_read_data1) < $signed(ID_read_data2))
                                : (ID_read_data1 < ID_read_data2);

  assign taken = is_jump
               | (is_beq & (ID_read_data1 == ID_read_data2))
               | (is_bne & (ID_read_data1 != ID_read_data2))
               | (is_blt & lt)
               | (is_bge & ~lt);

  assign br_imm     = ADDR_W'($signed(ID_instruction[15:0]));
  assign br_target  = ID_pcplus4 + (br_imm << 2);
  assign j_target   = {ID_pcplus4[ADDR_W-1:28], ID_instruction[25:0], 2'b00};
  assign act_target = is_jump ? j_target : br_target;
  assign id_pc      = ID_pcplus4 - ADDR_W'(4);
  assign id_idx     = id_pc[IDX_W+1:2];
  assign id_tag     = id_pc[ADDR_W-1:IDX_W+2];
  assign id_hit     = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  // Redirect on wrong direction or wrong target
  always_comb begin
    pcsrc   = 1'b0;
    pc_addr = ID_pcplus4;
    if (ID_valid) begin
      if (taken && (!ID_pred_taken || (ID_pred_target != act_target))) begin
        pcsrc   = 1'b1;
        pc_addr = act_target;
      end else if (!taken && ID_pred_taken) begin
        pcsrc   = 1'b1;
        pc_addr = ID_pcplus4;
      end
    end
    IFID_flush = pcsrc;
  end

  // Next contents of the ID-indexed entry
  logic              upd_en, upd_valid;
  logic [TAG_W-1:0]  upd_tag;
  logic [ADDR_W-1:0] upd_target;
  logic [CNT_W-1:0]  upd_cnt;

  always_comb begin
    upd_en     = 1'b0;
    upd_valid  = valid_q[id_idx];
    upd_tag    = tag_q[id_idx];
    upd_target = target_q[id_idx];
    upd_cnt    = cnt_q[id_idx];
    if (ID_valid) begin
      if (is_cti) begin
        if (id_hit) begin
          upd_en = 1'b1;
          if (is_jump)
            upd_cnt = CNT_MAX;
          else if (taken)
            upd_cnt = (cnt_q[id_idx] == CNT_MAX) ? CNT_MAX : cnt_q[id_idx] + CNT_W'(1);
          else
            upd_cnt = (cnt_q[id_idx] == '0) ? '0 : cnt_q[id_idx] - CNT_W'(1);
          if (taken)
            upd_target = act_target;
        end else if (taken) begin
          upd_en     = 1'b1;
          upd_valid  = 1'b1;
          upd_tag    = id_tag;
          upd_target = act_target;
          upd_cnt    = is_jump ? CNT_MAX : CNT_WT;
        end
      end else if (id_hit) begin
        // A non-branch matching an entry means the entry is stale
        upd_en    = 1'b1;
        upd_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (upd_en) begin
      valid_q[id_idx]  <= upd_valid;
      tag_q[id_idx]    <= upd_tag;
      target_q[id_idx] <= upd_target;
      cnt_q[id_idx]    <= upd_cnt;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ID_valid && is_cti && (branch_count != 16'hFFFF))
        branch_count <= branch_count + 16'd1;
      if (pcsrc && (mispredict_count != 16'hFFFF))
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{IF_pc[1:0], id_pc[1:0]};

endmodule
